// File: rtl/vector_lane_sequencer.sv
// Issues latched vector operands LANE_NUM elements per cycle and assembles vd.
// Optional perf_active_elems counter: define VECTOR_LANE_SEQ_PERF_CNT_EN.
module vector_lane_sequencer #(
  parameter int LEN              = 32,
  parameter int VECTOR_SIZE      = 8,
  parameter int ENTRY_INDEX_SIZE = 3,
  parameter int LANE_INDEX_SIZE  = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [ENTRY_INDEX_SIZE:0]     vl,
  input  logic                          vm,
  input  logic [VECTOR_SIZE-1:0]        mask_bits,
  input  logic [VECTOR_SIZE*LEN-1:0]    vs1_data,
  input  logic [VECTOR_SIZE*LEN-1:0]    vs2_data,
  input  logic [VECTOR_SIZE*LEN-1:0]    vd_old,
  output logic [(2**LANE_INDEX_SIZE)*LEN-1:0] lane_vs1,
  output logic [(2**LANE_INDEX_SIZE)*LEN-1:0] lane_vs2,
  output logic [(2**LANE_INDEX_SIZE)-1:0]     lane_active,
  input  logic [(2**LANE_INDEX_SIZE)*LEN-1:0] alu_result,
`ifdef VECTOR_LANE_SEQ_PERF_CNT_EN
  output logic [31:0]                   perf_active_elems,
`endif
  output logic                          busy,
  output logic                          done,
  output logic [VECTOR_SIZE*LEN-1:0]    vd_data,
  output logic [VECTOR_SIZE-1:0]        vd_elem_we
);

  localparam int LANE_NUM = 2**LANE_INDEX_SIZE;
  localparam int EW       = ENTRY_INDEX_SIZE + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_e;

  state_e                     state_q, state_d;
  logic [EW-1:0]              vl_q, vl_clamp;
  logic [EW-1:0]              grp_q, next_base;
  logic                       last_grp;
  logic                       vm_q;
  logic [VECTOR_SIZE-1:0]     mask_q;
  logic [VECTOR_SIZE*LEN-1:0] vs1_q, vs2_q;
  logic [VECTOR_SIZE*LEN-1:0] vd_q, vd_d;
  logic [VECTOR_SIZE-1:0]     we_q, we_d;
  logic [LANE_NUM-1:0]        act;

  assign vl_clamp  = (vl > EW'(VECTOR_SIZE))
                   ? EW'(VECTOR_SIZE) : vl;
  assign next_base = (grp_q + EW'(1)) << LANE_INDEX_SIZE;
  assign last_grp  = (next_base >= vl_q);

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (start)
          state_d = (vl_clamp == '0) ? S_DONE : S_BUSY;
      end
      S_BUSY: begin
        if (last_grp) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy        = 1'b0;
    done        = 1'b0;
    lane_active = '0;
    unique case (state_q)
      S_IDLE: ;
      S_BUSY: begin
        busy        = 1'b1;
        lane_active = act;
      end
      S_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  // Per-lane element select plus the merged destination for this group.
  always_comb begin : lane_mux
    int e;
    e        = 0;
    lane_vs1 = '0;
    lane_vs2 = '0;
    act      = '0;
    vd_d     = vd_q;
    we_d     = we_q;
    for (int i = 0; i < LANE_NUM; i++) begin
      e = int'(grp_q) * LANE_NUM + i;
      if (e < VECTOR_SIZE) begin
        lane_vs1[i*LEN +: LEN] = vs1_q[e*LEN +: LEN];
        lane_vs2[i*LEN +: LEN] = vs2_q[e*LEN +: LEN];
        act[i] = (e < int'(vl_q)) && (vm_q || mask_q[e]);
        if (act[i]) begin
          vd_d[e*LEN +: LEN] = alu_result[i*LEN +: LEN];
          we_d[e]            = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vl_q   <= '0;
      vm_q   <= 1'b0;
      mask_q <= '0;
      vs1_q  <= '0;
      vs2_q  <= '0;
      vd_q   <= '0;
      we_q   <= '0;
      grp_q  <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            vl_q   <= vl_clamp;
            vm_q   <= vm;
            mask_q <= mask_bits;
            vs1_q  <= vs1_data;
            vs2_q  <= vs2_data;
            vd_q   <= vd_old;
            we_q   <= '0;
            grp_q  <= '0;
          end
        end
        S_BUSY: begin
          vd_q  <= vd_d;
          we_q  <= we_d;
          grp_q <= grp_q + EW'(1);
        end
        S_DONE: ;
        default: ;
      endcase
    end
  end

  assign vd_data    = vd_q;
  assign vd_elem_we = we_q;

`ifdef VECTOR_LANE_SEQ_PERF_CNT_EN
  logic [31:0]            perf_q, perf_d;
  logic [LANE_INDEX_SIZE:0] pop;
  logic [32:0]            sum;

  always_comb begin
    pop = '0;
    for (int i = 0; i < LANE_NUM; i++)
      pop = pop + (LANE_INDEX_SIZE+1)'(lane_active[i]);
    sum    = {1'b0, perf_q} + 33'(pop);
    perf_d = sum[32] ? 32'hFFFF_FFFF : sum[31:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n)                 perf_q <= '0;
    else if (state_q == S_BUSY) perf_q <= perf_d;
  end

  assign perf_active_elems = perf_q;
`endif

endmodule

// File: tb/tb_vector_lane_sequencer.sv
// Directed self-checking bench for vector_lane_sequencer.
// ALU model: per-lane vs1 + vs2.
module tb_vector_lane_sequencer;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [3:0]   vl;
  logic         vm;
  logic [7:0]   mask_bits;
  logic [255:0] vs1_data, vs2_data, vd_old;
  logic [63:0]  lane_vs1, lane_vs2;
  logic [1:0]   lane_active;
  logic [63:0]  alu_result;
  logic         busy, done;
  logic [255:0] vd_data;
  logic [7:0]   vd_elem_we;
`ifdef VECTOR_LANE_SEQ_PERF_CNT_EN
  logic [31:0]  perf;
`endif

  int vectors;
  int miscompares;

  vector_lane_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .vl          (vl),
    .vm          (vm),
    .mask_bits   (mask_bits),
    .vs1_data    (vs1_data),
    .vs2_data    (vs2_data),
    .vd_old      (vd_old),
    .lane_vs1    (lane_vs1),
    .lane_vs2    (lane_vs2),
    .lane_active (lane_active),
    .alu_result  (alu_result),
`ifdef VECTOR_LANE_SEQ_PERF_CNT_EN
    .perf_active_elems (perf),
`endif
    .busy        (busy),
    .done        (done),
    .vd_data     (vd_data),
    .vd_elem_we  (vd_elem_we)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    alu_result[31:0]  = lane_vs1[31:0]  + lane_vs2[31:0];
    alu_result[63:32] = lane_vs1[63:32] + lane_vs2[63:32];
  end

  task automatic chk(input string tag,
                     input logic [255:0] obs,
                     input logic [255:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run(input string nm,
                     input logic [3:0] vl_v,
                     input logic vm_v,
                     input logic [7:0] mk,
                     input logic [255:0] old,
                     input int exp_g,
                     input logic [7:0] exp_we,
                     input logic [1:0] exp_last,
                     input bit pulse);
    logic [255:0] exp_vd;
    logic [1:0]   last_la;
    int           cyc;
    bit           seen;
    for (int k = 0; k < 8; k++)
      exp_vd[k*32 +: 32] = exp_we[k] ? 32'(11*k)
                                     : old[k*32 +: 32];
    @(negedge clk);
    vl = vl_v; vm = vm_v; mask_bits = mk;
    vd_old = old; start = 1'b1;
    @(posedge clk); #1;
    start = pulse;
    cyc = 0;
    last_la = '0;
    while (!done && cyc < 20) begin
      last_la = lane_active;
      cyc++;
      @(posedge clk); #1;
      start = pulse;
    end
    chk({nm, " busy_cycles"}, 256'(cyc), 256'(exp_g));
    chk({nm, " done"}, 256'(done), 256'(1));
    chk({nm, " busy_in_done"}, 256'(busy), 256'(1));
    chk({nm, " la_in_done"}, 256'(lane_active), 256'(0));
    chk({nm, " vd_data"}, vd_data, exp_vd);
    chk({nm, " vd_elem_we"}, 256'(vd_elem_we), 256'(exp_we));
    if (exp_g > 0)
      chk({nm, " last_lane_active"}, 256'(last_la), 256'(exp_last));
    @(posedge clk); #1;
    start = 1'b0;
    chk({nm, " idle_busy"}, 256'({busy, done}), 256'(0));
    chk({nm, " vd_hold"}, vd_data, exp_vd);
    if (pulse) begin
      seen = 1'b0;
      repeat (6) begin
        @(posedge clk); #1;
        if (done || busy) seen = 1'b1;
      end
      chk({nm, " no_extra_done"}, 256'(seen), 256'(0));
    end
  endtask

  logic [255:0] ones, alt;

  initial begin
    bit seen;
    vectors = 0;
    miscompares = 0;
    rst_n = 1'b0; start = 1'b0; vl = '0; vm = 1'b1;
    mask_bits = '0; vd_old = '0;
    for (int k = 0; k < 8; k++) begin
      vs1_data[k*32 +: 32] = 32'(k);
      vs2_data[k*32 +: 32] = 32'(10*k);
      ones[k*32 +: 32]     = 32'hFFFF_FFFF;
      alt[k*32 +: 32]      = 32'hDEAD_0000 + 32'(k);
    end
    repeat (2) @(posedge clk);
    #1;
    chk("rst busy_done", 256'({busy, done}), 256'(0));
    chk("rst lane_active", 256'(lane_active), 256'(0));
    chk("rst vd_elem_we", 256'(vd_elem_we), 256'(0));
    chk("rst vd_data", vd_data, 256'(0));
    chk("rst lanes", 256'({lane_vs1, lane_vs2}), 256'(0));
`ifdef VECTOR_LANE_SEQ_PERF_CNT_EN
    chk("rst perf", 256'(perf), 256'(0));
`endif
    @(negedge clk);
    rst_n = 1'b1;

    run("mask_a5", 4'd8, 1'b0, 8'hA5, ones, 4, 8'hA5, 2'b10, 1'b0);
`ifdef VECTOR_LANE_SEQ_PERF_CNT_EN
    chk("perf after mask", 256'(perf), 256'(4));
`endif
    run("vl8", 4'd8, 1'b1, 8'h00, ones, 4, 8'hFF, 2'b11, 1'b0);
`ifdef VECTOR_LANE_SEQ_PERF_CNT_EN
    chk("perf after vl8", 256'(perf), 256'(12));
`endif
    run("vl5", 4'd5, 1'b1, 8'h00, ones, 3, 8'h1F, 2'b01, 1'b0);
    run("vl0", 4'd0, 1'b1, 8'h00, alt, 0, 8'h00, 2'b00, 1'b0);
    run("vl12", 4'd12, 1'b1, 8'h00, alt, 4, 8'hFF, 2'b11, 1'b0);
    run("ign_start", 4'd5, 1'b1, 8'h00, ones, 3, 8'h1F, 2'b01, 1'b1);

    @(negedge clk);
    vl = 4'd8; vm = 1'b1; vd_old = ones; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    chk("midrst busy_before", 256'(busy), 256'(1));
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midrst busy_done", 256'({busy, done}), 256'(0));
    chk("midrst vd_data", vd_data, 256'(0));
    chk("midrst we", 256'({vd_elem_we, lane_active}), 256'(0));
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (done || busy) seen = 1'b1;
    end
    chk("midrst no_done", 256'(seen), 256'(0));
    run("post_rst", 4'd8, 1'b1, 8'h00, alt, 4, 8'hFF, 2'b11, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/vector_lane_sequencer.md
Name: vector_lane_sequencer

Overview:
- Element sequencer that sits directly upstream of the per-lane vector ALUs.
- Latches one vector instruction's full-width operands and issues LANE_NUM elements per cycle to the lane ALUs.
- Collects the combinational ALU results and applies mask and tail policy (masked-off and tail elements keep the old destination value).
- Assembles the destination vector and pulses done for writeback.

Parameters:
- LEN, 32, element width in bits
- VECTOR_SIZE, 8, elements per vector register
- ENTRY_INDEX_SIZE, 3, log2(VECTOR_SIZE)
- LANE_INDEX_SIZE, 1, log2 of lane count; LANE_NUM = 2**LANE_INDEX_SIZE (derived localparam, 2 by default)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  synchronous active-low reset
- start  in  1  launch request; sampled only in IDLE
- vl  in  ENTRY_INDEX_SIZE+1  active vector length; values >VECTOR_SIZE are clamped to VECTOR_SIZE
- vm  in  1  1 = unmasked, 0 = use mask_bits
- mask_bits  in  VECTOR_SIZE  v0 mask, bit i governs element i
- vs1_data  in  VECTOR_SIZE*LEN  operand vector; element i at [i*LEN +: LEN]
- vs2_data  in  VECTOR_SIZE*LEN  operand vector
- vd_old  in  VECTOR_SIZE*LEN  prior destination contents
- lane_vs1  out  LANE_NUM*LEN  per-lane vs1 element
- lane_vs2  out  LANE_NUM*LEN  per-lane vs2 element
- lane_active  out  LANE_NUM  lane i holds a valid, unmasked element this cycle
- alu_result  in  LANE_NUM*LEN  combinational per-lane ALU results, same cycle as issue
- busy  out  1  high in BUSY and DONE
- done  out  1  one-cycle completion pulse
- vd_data  out  VECTOR_SIZE*LEN  assembled destination vector
- vd_elem_we  out  VECTOR_SIZE  element-write enables, valid while done=1

Behaviour:
- Reset (rst_n=0 at edge): state=IDLE. busy, done, lane_active, vd_elem_we, group counter = 0. vd_data, lane_vs1, lane_vs2 = 0. Reset mid-operation aborts with no done pulse.
- IDLE, start=1:
  - latch vl (clamped), vm, mask_bits, vs1_data, vs2_data, vd_old
  - init vd_data := vd_old, group g := 0
  - go to BUSY, or directly to DONE if clamped vl=0
- IDLE, start=0: hold all state.
- BUSY, cycle for group g, lane i, element e = g*LANE_NUM+i:
  - valid(e) = e < vl
  - active(e) = valid(e) && (vm || mask_bits[e])
  - lane_vs1/lane_vs2 slices = latched elements e; lane_active[i] = active(e)
  - at the edge, vd_data[e] := alu_result[i] if active(e), otherwise unchanged (old value retained)
  - vd_elem_we[e] accumulates active(e)
- Group count G = ceil(vl/LANE_NUM). BUSY lasts exactly G cycles. After the last group, go to DONE.
- DONE: one cycle with done=1 and busy=1; lane_active=0. Next state is IDLE.
- vd_data and vd_elem_we hold their values until the next accepted start. vd_elem_we is cleared on accept.
- start while BUSY or DONE is ignored; there is no queueing.
- Latency: start accepted at edge T. BUSY covers cycles T+1..T+G. done is high in cycle T+G+1. If vl=0, done is high in cycle T+1 with vd_elem_we=0 and vd_data=vd_old.
- Outputs are driven from registered state only; no combinational path from start to outputs.
- Masked-off and tail elements: lane_active=0, but lane_vs1/lane_vs2 still carry data (don't-care).

Optional Feature:
- VECTOR_LANE_SEQ_PERF_CNT_EN defined: adds output perf_active_elems (32 bits).
  - reset to 0
  - incremented by popcount(lane_active) each BUSY cycle
  - saturates at 0xFFFFFFFF
  - unaffected by start/done
- Undefined: port and counter absent; behaviour otherwise identical.

Test Plan:
- Bench ALU model is alu_result = vs1+vs2 per lane.
- vl=8, vm=1, vs1[i]=i, vs2[i]=10*i, vd_old=all 0xFFFFFFFF -> 4 BUSY cycles; done in cycle T+5; vd_data[i]=11*i; vd_elem_we=0xFF.
- vl=5, vm=1, same operands -> 3 BUSY cycles; elements 0..4=11*i, elements 5..7=0xFFFFFFFF; vd_elem_we=0x1F; in last group lane_active=2'b01.
- vl=8, vm=0, mask_bits=0xA5 -> elements 0,2,5,7 = 11*i, others keep vd_old; vd_elem_we=0xA5; BUSY still 4 cycles.
- vl=0 start -> done in T+1, busy high one cycle, vd_data=vd_old, vd_elem_we=0; vl=12 -> treated as 8, 4 BUSY cycles.
- start pulses during BUSY/DONE ignored (exactly one done). rst_n=0 during the 2nd BUSY cycle -> next cycle busy=0, no done, vd_data=0. A subsequent start runs normally.
- With VECTOR_LANE_SEQ_PERF_CNT_EN: the mask 0xA5 case then the vl=8 unmasked case -> perf_active_elems = 4 then 12.
